// File: rtl/elbeth_alu_md.sv
// Elbeth RV32 EX-stage execution unit: single-cycle base ALU ops plus iterative
// shift-add multiply and restoring divide, with valid/ready handshakes on both sides.
module elbeth_alu_md #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             illegal_op
);
    localparam int CW = SHW + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [4:0]         op_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   rem, quo, divisor;
    logic               neg_q, neg_r;

    // Decode of the incoming opcode
    logic is_base, is_mul, is_div;
    assign is_base = (operation <= 5'd9);
    assign is_mul  = (operation[4:2] == 3'b100);
    assign is_div  = (operation[4:2] == 3'b101);

    logic [WIDTH-1:0] base_res;
    always_comb begin
        base_res = '0;
        case (operation)
            5'd0: base_res = data_a + data_b;
            5'd1: base_res = data_a - data_b;
            5'd2: base_res = data_a & data_b;
            5'd3: base_res = data_a | data_b;
            5'd4: base_res = data_a ^ data_b;
            5'd5: base_res = {{(WIDTH-1){1'b0}}, data_a < data_b};
            5'd6: base_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
            5'd7: base_res = data_a << data_b[SHW-1:0];
            5'd8: base_res = data_a >> data_b[SHW-1:0];
            5'd9: base_res = WIDTH'($signed(data_a) >>> data_b[SHW-1:0]);
            default: base_res = '0;
        endcase
    end

    // Multiply setup: MULHU treats a as unsigned; only MUL/MULH treat b as signed
    logic             a_sgn_m;
    logic [2*WIDTH-1:0] a_ext;
    assign a_sgn_m = (operation[1:0] != 2'd3);
    assign a_ext   = {{WIDTH{a_sgn_m & data_a[WIDTH-1]}}, data_a};

    // Divide setup: DIV/REM are the even opcodes, REM/REMU have bit 1 set
    logic             sgn_d, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign sgn_d    = ~operation[0];
    assign a_neg    = sgn_d & data_a[WIDTH-1];
    assign b_neg    = sgn_d & data_b[WIDTH-1];
    assign a_mag    = a_neg ? -data_a : data_a;
    assign b_mag    = b_neg ? -data_b : data_b;
    assign div_zero = (data_b == '0);
    assign div_ovf  = sgn_d && (data_a == MOST_NEG) && (data_b == '1);

    // Multiply step: a signed multiplier's top bit carries negative weight
    logic [2*WIDTH-1:0] addend, acc_nx;
    logic [WIDTH-1:0]   mul_res;
    always_comb begin
        addend  = ((cnt == CW'(WIDTH-1)) && (op_q[1:0] <= 2'd1)) ? -mcand : mcand;
        acc_nx  = mplier[0] ? acc + addend : acc;
        mul_res = (op_q[1:0] == 2'd0) ? acc_nx[WIDTH-1:0] : acc_nx[2*WIDTH-1:WIDTH];
    end

    // Restoring divide step; quo starts as the dividend and shifts quotient bits in
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_nx, quo_nx, div_res;
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        diff    = rem_sh - {1'b0, divisor};
        rem_nx  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};
        div_res = op_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            alu_result <= '0;
            illegal_op <= 1'b0;
            op_q       <= '0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q       <= operation;
                    cnt        <= '0;
                    in_ready   <= 1'b0;
                    illegal_op <= 1'b0;
                    if (is_mul) begin
                        state  <= MUL;
                        acc    <= '0;
                        mcand  <= a_ext;
                        mplier <= data_b;
                    end else if (is_div && !div_zero && !div_ovf) begin
                        state   <= DIV;
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (is_base)
                            alu_result <= base_res;
                        else if (is_div && div_zero)
                            alu_result <= operation[1] ? data_a : '1;
                        else if (is_div)
                            alu_result <= operation[1] ? '0 : MOST_NEG;
                        else begin
                            alu_result <= '0;
                            illegal_op <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        alu_result <= mul_res;
                    end
                end
                DIV: begin
                    if (cnt == CW'(WIDTH)) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        alu_result <= div_res;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elbeth_alu_md.sv
// Directed bench for elbeth_alu_md: hand-computed results, latencies, handshake
// hold, flush and asynchronous reset behaviour.
module tb_elbeth_alu_md;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, illegal_op;
    logic [4:0]  operation;
    logic [31:0] data_a, data_b, alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    elbeth_alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .operation(operation),
        .data_a(data_a), .data_b(data_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble operands after acceptance, measure latency to out_valid
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input logic ill);
        int cyc;
        bit got;
        @(negedge clk);
        in_valid = 1'b1; operation = op; data_a = a; data_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; data_a = $urandom; data_b = $urandom; operation = 5'($urandom);
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(lat));
        chk({tag, " result"}, alu_result, exp);
        chk({tag, " illegal"}, {31'd0, illegal_op}, {31'd0, ill});
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op_take(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        run_op(tag, op, a, b, exp, lat, 1'b0);
        take_result();
    endtask

    initial begin
        int hits;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operation = '0; data_a = '0; data_b = '0;
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset alu_result", alu_result, 32'd0);
        chk("reset illegal_op", {31'd0, illegal_op}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        op_take("ADD wrap", 5'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        op_take("SUB wrap", 5'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
        op_take("XOR", 5'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
        op_take("SLT", 5'd6, 32'h8000_0000, 32'h1, 32'h1, 1);
        op_take("SLTU", 5'd5, 32'h8000_0000, 32'h1, 32'h0, 1);
        op_take("SRA", 5'd9, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
        op_take("SRL", 5'd8, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
        op_take("SLL wrap", 5'd7, 32'h1, 32'h20, 32'h1, 1);

        op_take("MULH", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
        op_take("MULHU", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op_take("MULHSU", 5'd18, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
        op_take("MUL", 5'd16, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

        op_take("DIV", 5'd20, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34);
        op_take("REM", 5'd22, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34);
        op_take("DIVU", 5'd21, 32'd100, 32'd7, 32'd14, 34);
        op_take("REMU", 5'd23, 32'd100, 32'd7, 32'd2, 34);
        op_take("DIVU by 0", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        op_take("DIV ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        op_take("REM ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Result held while the consumer stalls
        run_op("REMU by 0", 5'd23, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold alu_result", alu_result, 32'd5);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        take_result();
        @(negedge clk);
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
        chk("release out_valid", {31'd0, out_valid}, 32'd0);

        run_op("illegal 31", 5'd31, 32'h1234, 32'h5678, 32'h0, 1, 1'b1);
        take_result();
        op_take("ADD after illegal", 5'd0, 32'd2, 32'd3, 32'd5, 1);

        // Flush ten cycles into a divide
        @(negedge clk);
        in_valid = 1'b1; operation = 5'd20; data_a = 32'hFFFF_FFF9; data_b = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush keeps result", alu_result, 32'd5);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk("flush no out_valid", 32'(hits), 32'd0);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; operation = 5'd16; data_a = 32'd7; data_b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("async rst alu_result", alu_result, 32'd0);
        chk("async rst illegal_op", {31'd0, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        chk("rst no out_valid", 32'(hits), 32'd0);
        op_take("MUL after rst", 5'd16, 32'd6, 32'd7, 32'd42, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
